cf_sector_arbiter: RTL
======================

# cf_sector_arbiter

Shares the single CF_Interface sector engine between two requesters: port 0 is the voicemail record path (writes) and port 1 is the playback path (reads), though either port may issue either operation. The block sits between the audio buffering logic and CF_Interface. It arbitrates round-robin, issues one command per grant and steers the word-level data handshake to the granted port. It also checks the transferred word count and reports completion or error per port.

## Interface
- WORDS_PER_SECTOR, 256: 16-bit words per sector.
- BUSY_TIMEOUT, 16: maximum cycles from command issue to cf_ready falling.
- clk_27mhz  in  1  system clock.
- reset_b  in  1  asynchronous, active-low reset.
- req_0/req_1  in  1  level request; sampled only in IDLE.
- op_0/op_1  in  1  1 = write, 0 = read.
- lba_0/lba_1  in  28  start LBA.
- sc_0/sc_1  in  8  sector count; 0 means 256.
- gnt_0/gnt_1  out  1  high from accept through DONE.
- done_0/done_1  out  1  one-cycle completion pulse.
- err_0/err_1  out  1  valid with done; 1 = failed.
- wr_data_0/wr_data_1  in  16  write word from the requester.
- wr_req_0/wr_req_1  out  1  word request, forwarded from cf_we_req.
- rd_data  out  16  read word, equal to cf_dout.
- rd_nd_0/rd_nd_1  out  1  read word valid, forwarded from cf_nd.
- cf_cmd  out  2  command to CF_Interface.
- cf_lba  out  28  LBA to CF_Interface.
- cf_sc  out  8  sector count to CF_Interface.
- cf_din  out  16  write data to CF_Interface.
- cf_we_req  in  1  CF_Interface write-word request.
- cf_dout  in  16  CF_Interface read word.
- cf_nd  in  1  CF_Interface read word strobe.
- cf_ready  in  1  CF_Interface idle.
- cf_detect  in  1  card present.

## Operation

**Reset values**
- All outputs are 0, and cf_cmd is CMD_NONE.
- The state is IDLE and last_grant is 1, so port 0 wins the first tie.

**IDLE**
- Arbitration happens only when cf_ready=1 and cf_detect=1.
- If only one req is high, that port is granted.
- If both are high, the port other than last_grant is granted.
- On grant, the block latches op/lba/sc into cf_lba/cf_sc, sets gnt_N, updates last_grant, clears the word counter and moves to ISSUE.

**ISSUE**
- Drives cf_cmd = CMD_WRITE or CMD_READ for exactly one cycle, then moves to WAIT_BUSY.

**WAIT_BUSY**
- Moves to XFER when cf_ready=0.
- If BUSY_TIMEOUT cycles pass without cf_ready falling, moves to DONE with err.

**XFER**
- The 17-bit word counter increments on each cf_we_req (write) or cf_nd (read).
- When cf_ready=1, the block compares the count against expected = (sc==0 ? 256 : sc) × WORDS_PER_SECTOR. A mismatch sets err. The block then moves to DONE.

**DONE**
- Pulses done_N (and err_N if set) for one cycle, drops gnt_N and returns to IDLE.

**Data steering** (combinational, zero latency)
- wr_req_N = cf_we_req & gnt_N & op_N.
- cf_din = granted port's wr_data, or 0 when nothing is granted.
- rd_nd_N = cf_nd & gnt_N & ~op_N.
- Strobes never reach a non-granted port.

**Boundary conditions**
- cf_detect falling in ISSUE, WAIT_BUSY or XFER: go to DONE with err. CF_Interface recovers on its own.
- req deasserted after grant: ignored; the transaction completes.
- req still high in the cycle after done: treated as a new request.
- Counter overflow: not possible, since 17 bits covers 65536.
- Strobes arriving in IDLE: ignored, and nothing is forwarded.

## Timing
- req high (with cf_ready=1 and cf_detect=1) at edge k: gnt at k+1, cf_cmd valid during k+1 to k+2.
- Minimum turnaround from done to the next cf_cmd: 2 cycles.
- cf_lba and cf_sc are stable from ISSUE through DONE.
- Round-robin alternates ports under continuous dual request, so neither port starves.

## Structure
- Package cf_pkg holds:
  - CMD_NONE=2'b00, CMD_READ=2'b01, CMD_WRITE=2'b10, CMD_IDENTIFY=2'b11 (unused here).
  - The state encoding: IDLE, ISSUE, WAIT_BUSY, XFER, DONE.
  - The WORDS_PER_SECTOR default.
- Sub-module cf_rr_arbiter: 2-way round-robin with last_grant, combinational grant plus registered pointer.

## Test plan
- req_0 write, lba 0x0000100, sc 1; CF model drops ready after 3 cycles and issues 256 we_req -> cf_cmd=10 for one cycle, wr_req_0 ×256, done_0=1, err_0=0.
- req_0 and req_1 high simultaneously after reset -> port 0 is served first, then port 1. Reassert both -> port 0 served again only after port 1, confirming alternation.
- Read with sc=0; model sends 65536 nd -> done_1, err_1=0. Model sends 65535 -> err_1=1.
- Model never drops cf_ready -> err at BUSY_TIMEOUT+2 cycles after grant, and cf_cmd is not reissued.
- cf_detect falls mid-XFER -> next cycle DONE with err set, gnt dropped, no further strobes forwarded.
- reset_b asserted mid-XFER -> all outputs are 0 asynchronously; after release, the first request goes to port 0.

Source files
------------

// File: rtl/cf_pkg.sv
// Shared command codes, FSM encoding and sizing helpers for the CF sector arbiter.
package cf_pkg;

  localparam logic [1:0] CMD_NONE     = 2'b00;
  localparam logic [1:0] CMD_READ     = 2'b01;
  localparam logic [1:0] CMD_WRITE    = 2'b10;
  localparam logic [1:0] CMD_IDENTIFY = 2'b11;

  localparam int unsigned WORDS_PER_SECTOR_DEF = 256;
  localparam int unsigned BUSY_TIMEOUT_DEF     = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_XFER,
    S_DONE
  } cf_state_e;

  // A sector count of 0 means 256 sectors, so the product needs 17 bits.
  function automatic logic [16:0] expected_words(input logic [7:0] sc, input int unsigned wps);
    logic [31:0] sectors;
    sectors = (sc == 8'd0) ? 32'd256 : {24'd0, sc};
    return 17'(sectors * wps);
  endfunction

endpackage

// File: rtl/cf_rr_arbiter.sv
// Two-way round-robin arbiter: combinational pick, registered last-grant pointer.
module cf_rr_arbiter (
  input  logic clk,
  input  logic rst_n,
  input  logic req_0,
  input  logic req_1,
  input  logic accept,
  output logic valid,
  output logic sel
);

  logic last_grant;

  always_comb begin
    valid = req_0 | req_1;
    if (req_0 && req_1) sel = ~last_grant;
    else                sel = req_1;
  end

  // Reset to port 1 so that port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= 1'b1;
    else if (accept) last_grant <= sel;
  end

endmodule

// File: rtl/cf_sector_arbiter.sv
// Shares the CF_Interface sector engine between two requesters; one command per
// grant, word strobes steered to the granted port, word count checked at the end.
module cf_sector_arbiter
  import cf_pkg::*;
#(
  parameter int unsigned WORDS_PER_SECTOR = WORDS_PER_SECTOR_DEF,
  parameter int unsigned BUSY_TIMEOUT     = BUSY_TIMEOUT_DEF
) (
  input  logic        clk_27mhz,
  input  logic        reset_b,
  input  logic        req_0,
  input  logic        req_1,
  input  logic        op_0,
  input  logic        op_1,
  input  logic [27:0] lba_0,
  input  logic [27:0] lba_1,
  input  logic [7:0]  sc_0,
  input  logic [7:0]  sc_1,
  output logic        gnt_0,
  output logic        gnt_1,
  output logic        done_0,
  output logic        done_1,
  output logic        err_0,
  output logic        err_1,
  input  logic [15:0] wr_data_0,
  input  logic [15:0] wr_data_1,
  output logic        wr_req_0,
  output logic        wr_req_1,
  output logic [15:0] rd_data,
  output logic        rd_nd_0,
  output logic        rd_nd_1,
  output logic [1:0]  cf_cmd,
  output logic [27:0] cf_lba,
  output logic [7:0]  cf_sc,
  output logic [15:0] cf_din,
  input  logic        cf_we_req,
  input  logic [15:0] cf_dout,
  input  logic        cf_nd,
  input  logic        cf_ready,
  input  logic        cf_detect,
  output cf_state_e   state
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  logic          arb_valid, arb_sel, accept, sel_op;
  logic          op_q, inc, to_done, fail;
  logic [TW-1:0] timer;
  logic [16:0]   cnt, cnt_next, exp_words;

  cf_rr_arbiter u_arb (
    .clk    (clk_27mhz),
    .rst_n  (reset_b),
    .req_0  (req_0),
    .req_1  (req_1),
    .accept (accept),
    .valid  (arb_valid),
    .sel    (arb_sel)
  );

  assign accept    = (state == S_IDLE) && arb_valid && cf_ready && cf_detect;
  assign sel_op    = arb_sel ? op_1 : op_0;
  assign inc       = (state == S_XFER) && (op_q ? cf_we_req : cf_nd);
  assign cnt_next  = cnt + {16'd0, inc};
  assign exp_words = expected_words(cf_sc, WORDS_PER_SECTOR);

  // Steering is gated by the grant, so nothing leaks out in IDLE or after reset.
  assign wr_req_0 = cf_we_req & gnt_0 & op_q;
  assign wr_req_1 = cf_we_req & gnt_1 & op_q;
  assign rd_nd_0  = cf_nd & gnt_0 & ~op_q;
  assign rd_nd_1  = cf_nd & gnt_1 & ~op_q;
  assign rd_data  = cf_dout;
  assign cf_din   = gnt_0 ? wr_data_0 : (gnt_1 ? wr_data_1 : 16'd0);

  // Card loss outranks every other exit from an active transaction.
  always_comb begin
    to_done = 1'b0;
    fail    = 1'b0;
    if ((state == S_ISSUE) || (state == S_WAIT_BUSY) || (state == S_XFER)) begin
      if (!cf_detect) begin
        to_done = 1'b1;
        fail    = 1'b1;
      end else if ((state == S_WAIT_BUSY) && cf_ready && (timer == TW'(BUSY_TIMEOUT))) begin
        to_done = 1'b1;
        fail    = 1'b1;
      end else if ((state == S_XFER) && cf_ready) begin
        to_done = 1'b1;
        fail    = (cnt_next != exp_words);
      end
    end
  end

  always_ff @(posedge clk_27mhz or negedge reset_b) begin
    if (!reset_b) begin
      state  <= S_IDLE;
      gnt_0  <= 1'b0;
      gnt_1  <= 1'b0;
      done_0 <= 1'b0;
      done_1 <= 1'b0;
      err_0  <= 1'b0;
      err_1  <= 1'b0;
      cf_cmd <= CMD_NONE;
      cf_lba <= '0;
      cf_sc  <= '0;
      op_q   <= 1'b0;
      cnt    <= '0;
      timer  <= '0;
    end else begin
      done_0 <= 1'b0;
      done_1 <= 1'b0;
      err_0  <= 1'b0;
      err_1  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state  <= S_ISSUE;
            gnt_0  <= ~arb_sel;
            gnt_1  <= arb_sel;
            op_q   <= sel_op;
            cf_cmd <= sel_op ? CMD_WRITE : CMD_READ;
            cf_lba <= arb_sel ? lba_1 : lba_0;
            cf_sc  <= arb_sel ? sc_1 : sc_0;
            cnt    <= '0;
            timer  <= '0;
          end
        end
        S_ISSUE: begin
          cf_cmd <= CMD_NONE;
          state  <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!cf_ready) state <= S_XFER;
          else           timer <= timer + 1'b1;
        end
        S_XFER: cnt <= cnt_next;
        S_DONE: begin
          gnt_0 <= 1'b0;
          gnt_1 <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (to_done) begin
        state  <= S_DONE;
        done_0 <= gnt_0;
        done_1 <= gnt_1;
        err_0  <= gnt_0 & fail;
        err_1  <= gnt_1 & fail;
      end
    end
  end

endmodule
